hazard_scoreboard: RTL and testbench

//  Parametrised forwarding/hazard unit for the rv32im pipeline. It keeps the

---
 rtl/hazard_scoreboard_if.sv | 36 +++
 rtl/hazard_scoreboard.sv | 80 ++++++++
 tb/tb_hazard_scoreboard.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: operand, pipeline-stage and MUL/DIV signals shared between the pipeline and the hazard unit
//   slave  (hazard unit): takes ID/stage/lat inputs, drives fwd_sel, stall, pend_cnt, sb_full
//   master (pipeline)   : the mirror image
interface hazard_scoreboard_if #(
   parameter int NUM_SRC        = 2,
   parameter int NUM_FWD_STAGES = 3,
   parameter int AW             = 5,
   parameter int MAX_PEND       = 4
);
   localparam int FWD_W = $clog2(NUM_FWD_STAGES + 2);
   localparam int PW    = $clog2(MAX_PEND + 1);
   logic [NUM_SRC*AW-1:0]        id_rs;
   logic [NUM_SRC-1:0]           id_rs_used;
   logic [AW-1:0]                id_rd;
   logic                         id_regwrite;
   logic [NUM_FWD_STAGES*AW-1:0] st_rd;
   logic [NUM_FWD_STAGES-1:0]    st_regwrite;
   logic                         ex_memread;
   logic                         lat_issue;
   logic                         lat_done;
   logic [AW-1:0]                lat_rd;
   logic [NUM_SRC*FWD_W-1:0]     fwd_sel;
   logic                         stall;
   logic [PW-1:0]                pend_cnt;
   logic                         sb_full;
   modport slave (
      input  id_rs, id_rs_used, id_rd, id_regwrite, st_rd, st_regwrite,
             ex_memread, lat_issue, lat_done, lat_rd,
      output fwd_sel, stall, pend_cnt, sb_full
   );
   modport master (
      output id_rs, id_rs_used, id_rd, id_regwrite, st_rd, st_regwrite,
             ex_memread, lat_issue, lat_done, lat_rd,
      input  fwd_sel, stall, pend_cnt, sb_full
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: priority forwarding, load-use stall and MUL/DIV write scoreboard for the rv32im pipeline
//   clk   : clock
//   rst_n : async active-low reset, clears busy bits and pending count
//   sb    : hazard_scoreboard_if.slave (ID operands, stage rd/regwrite, lat issue/done in; fwd_sel, stall, pend_cnt, sb_full out)
module hazard_scoreboard #(
   parameter int NUM_SRC        = 2,
   parameter int NUM_FWD_STAGES = 3,
   parameter int AW             = 5,
   parameter int MAX_PEND       = 4
) (
   input logic               clk,
   input logic               rst_n,
   hazard_scoreboard_if.slave sb
);
   localparam int FWD_W = $clog2(NUM_FWD_STAGES + 2);
   localparam int PW    = $clog2(MAX_PEND + 1);
   logic [2**AW-1:0]         busy_q, busy_d;
   logic [PW-1:0]            pend_q, pend_d;
   logic [NUM_SRC*FWD_W-1:0] fwd_sel;
   logic [AW-1:0]            rs;
   logic [FWD_W-1:0]         sel;
   logic                     act, lat_hit, stall, full, waw;
   logic [AW-1:0]            ex_rd;
   assign ex_rd = sb.st_rd[AW-1:0];
   assign full  = pend_q == PW'(MAX_PEND);
   // A completing result on the lat bus resolves the hazard in the same cycle.
   assign waw = sb.id_regwrite && sb.id_rd != '0 && busy_q[sb.id_rd] &&
                !(sb.lat_done && sb.lat_rd == sb.id_rd);
   always_comb begin
      fwd_sel = '0;
      stall   = waw | (full & sb.id_regwrite);
      rs      = '0;
      sel     = '0;
      act     = 1'b0;
      lat_hit = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         rs      = sb.id_rs[k*AW +: AW];
         act     = sb.id_rs_used[k] && rs != '0;
         lat_hit = sb.lat_done && sb.lat_rd == rs;
         sel     = (act && lat_hit) ? FWD_W'(NUM_FWD_STAGES + 1) : '0;
         // Walk from the oldest stage down so the nearest producer overrides.
         for (int s = NUM_FWD_STAGES - 1; s >= 0; s--)
            if (act && sb.st_regwrite[s] && sb.st_rd[s*AW +: AW] == rs) sel = FWD_W'(s + 1);
         fwd_sel[k*FWD_W +: FWD_W] = sel;
         stall = stall | (sb.ex_memread && sel == FWD_W'(1))
                       | (sb.lat_issue && act && rs == ex_rd)
                       | (act && busy_q[rs] && !lat_hit);
      end
   end
   always_comb begin
      busy_d = busy_q;
      if (sb.lat_done) busy_d[sb.lat_rd] = 1'b0;
      // Issue is applied after done so a same-rd issue/done pair leaves the bit set.
      if (sb.lat_issue && ex_rd != '0) busy_d[ex_rd] = 1'b1;
      pend_d = (sb.lat_issue && !sb.lat_done && !full)        ? pend_q + 1'b1 :
               (sb.lat_done && !sb.lat_issue && pend_q != '0) ? pend_q - 1'b1 : pend_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         pend_q <= '0;
      end else begin
         busy_q <= busy_d;
         pend_q <= pend_d;
      end
   end
   assign sb.fwd_sel  = fwd_sel;
   assign sb.stall    = stall;
   assign sb.pend_cnt = pend_q;
   assign sb.sb_full  = full;
`ifndef SYNTHESIS
   // A simultaneous completion frees the slot, so only a net overflow/underflow is an error.
   a_issue_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(sb.lat_issue && !sb.lat_done && full))
      else $error("hazard_scoreboard: lat_issue while scoreboard full");
   a_done_empty: assert property (@(posedge clk) disable iff (!rst_n)
      !(sb.lat_done && !sb.lat_issue && pend_q == '0))
      else $error("hazard_scoreboard: lat_done with nothing pending");
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven forwarding vectors plus multi-cycle scoreboard sequences for hazard_scoreboard
module tb_hazard_scoreboard;
   typedef struct {
      logic [4:0] rs1, rs2;
      logic [1:0] used;
      logic [4:0] sr0, sr1, sr2;
      logic [2:0] srw;
      logic       mr;
      logic [2:0] f0, f1;
      logic       st;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t v[11];
   always #5 clk = ~clk;
   hazard_scoreboard_if hs();
   hazard_scoreboard dut (.clk(clk), .rst_n(rst_n), .sb(hs.slave));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic quiet();
      hs.id_rs = '0; hs.id_rs_used = '0; hs.id_rd = '0; hs.id_regwrite = 1'b0;
      hs.st_rd = '0; hs.st_regwrite = '0; hs.ex_memread = 1'b0;
      hs.lat_issue = 1'b0; hs.lat_done = 1'b0; hs.lat_rd = '0;
   endtask
   task automatic src(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] used);
      hs.id_rs = {rs2, rs1};
      hs.id_rs_used = used;
   endtask
   initial begin
      //        rs1    rs2    used   sr0    sr1    sr2    srw     mr    f0    f1    st
      v[0]  = '{5'd5,  5'd0,  2'b11, 5'd5,  5'd0,  5'd0,  3'b001, 1'b0, 3'd1, 3'd0, 1'b0};
      v[1]  = '{5'd5,  5'd6,  2'b11, 5'd6,  5'd5,  5'd5,  3'b111, 1'b0, 3'd2, 3'd1, 1'b0};
      v[2]  = '{5'd0,  5'd0,  2'b11, 5'd0,  5'd0,  5'd0,  3'b001, 1'b0, 3'd0, 3'd0, 1'b0};
      v[3]  = '{5'd5,  5'd5,  2'b10, 5'd5,  5'd0,  5'd0,  3'b001, 1'b0, 3'd0, 3'd1, 1'b0};
      v[4]  = '{5'd3,  5'd7,  2'b11, 5'd7,  5'd0,  5'd0,  3'b001, 1'b1, 3'd0, 3'd1, 1'b1};
      v[5]  = '{5'd3,  5'd7,  2'b11, 5'd0,  5'd7,  5'd0,  3'b010, 1'b0, 3'd0, 3'd2, 1'b0};
      v[6]  = '{5'd3,  5'd7,  2'b01, 5'd7,  5'd0,  5'd0,  3'b001, 1'b1, 3'd0, 3'd0, 1'b0};
      v[7]  = '{5'd8,  5'd0,  2'b01, 5'd0,  5'd8,  5'd8,  3'b110, 1'b0, 3'd2, 3'd0, 1'b0};
      v[8]  = '{5'd12, 5'd12, 2'b11, 5'd0,  5'd0,  5'd12, 3'b100, 1'b0, 3'd3, 3'd3, 1'b0};
      v[9]  = '{5'd5,  5'd0,  2'b11, 5'd5,  5'd0,  5'd0,  3'b000, 1'b1, 3'd0, 3'd0, 1'b0};
      v[10] = '{5'd4,  5'd4,  2'b11, 5'd4,  5'd0,  5'd0,  3'b001, 1'b1, 3'd1, 3'd1, 1'b1};
      quiet();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_fwd", 32'(hs.fwd_sel), 32'd0);
      chk("rst_stall", 32'(hs.stall), 32'd0);
      chk("rst_pend", 32'(hs.pend_cnt), 32'd0);
      chk("rst_full", 32'(hs.sb_full), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         quiet();
         src(v[i].rs1, v[i].rs2, v[i].used);
         hs.st_rd = {v[i].sr2, v[i].sr1, v[i].sr0};
         hs.st_regwrite = v[i].srw;
         hs.ex_memread = v[i].mr;
         #1;
         chk($sformatf("vec%0d_fwd", i), 32'(hs.fwd_sel), 32'({v[i].f1, v[i].f0}));
         chk($sformatf("vec%0d_stall", i), 32'(hs.stall), 32'(v[i].st));
      end
      @(negedge clk);
      quiet();
      hs.lat_issue = 1'b1; hs.st_rd = 15'd9; hs.st_regwrite = 3'b001;
      src(5'd9, 5'd0, 2'b01);
      #1;
      chk("issue_fwd", 32'(hs.fwd_sel), 32'd1);
      chk("issue_stall", 32'(hs.stall), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         quiet();
         src(5'd9, 5'd0, 2'b01);
         #1;
         chk($sformatf("busy9_stall%0d", i), 32'(hs.stall), 32'd1);
         chk($sformatf("busy9_pend%0d", i), 32'(hs.pend_cnt), 32'd1);
      end
      @(negedge clk);
      hs.lat_done = 1'b1; hs.lat_rd = 5'd9;
      #1;
      chk("done9_stall", 32'(hs.stall), 32'd0);
      chk("done9_fwd", 32'(hs.fwd_sel), 32'd4);
      @(negedge clk);
      quiet();
      src(5'd9, 5'd0, 2'b01);
      #1;
      chk("after9_stall", 32'(hs.stall), 32'd0);
      chk("after9_pend", 32'(hs.pend_cnt), 32'd0);
      chk("after9_fwd", 32'(hs.fwd_sel), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         quiet();
         hs.lat_issue = 1'b1; hs.st_rd = 15'(k);
         #1;
         chk($sformatf("fill_pend%0d", k), 32'(hs.pend_cnt), 32'(k - 1));
      end
      @(negedge clk);
      quiet();
      #1;
      chk("full_pend", 32'(hs.pend_cnt), 32'd4);
      chk("full_flag", 32'(hs.sb_full), 32'd1);
      chk("full_idle_stall", 32'(hs.stall), 32'd0);
      hs.id_regwrite = 1'b1; hs.id_rd = 5'd10;
      #1;
      chk("full_struct_stall", 32'(hs.stall), 32'd1);
      @(negedge clk);
      quiet();
      hs.lat_issue = 1'b1; hs.st_rd = 15'd2; hs.lat_done = 1'b1; hs.lat_rd = 5'd2;
      @(negedge clk);
      quiet();
      src(5'd2, 5'd0, 2'b01);
      #1;
      chk("same_rd_busy2", 32'(hs.stall), 32'd1);
      chk("same_rd_pend", 32'(hs.pend_cnt), 32'd4);
      @(negedge clk);
      quiet();
      hs.lat_done = 1'b1; hs.lat_rd = 5'd1;
      @(negedge clk);
      quiet();
      src(5'd1, 5'd0, 2'b01);
      #1;
      chk("drain_pend", 32'(hs.pend_cnt), 32'd3);
      chk("drain_full", 32'(hs.sb_full), 32'd0);
      chk("drain_rs1_stall", 32'(hs.stall), 32'd0);
      quiet();
      hs.id_regwrite = 1'b1; hs.id_rd = 5'd2;
      #1;
      chk("waw_stall", 32'(hs.stall), 32'd1);
      hs.lat_done = 1'b1; hs.lat_rd = 5'd2;
      #1;
      chk("waw_done_stall", 32'(hs.stall), 32'd0);
      quiet();
      hs.id_regwrite = 1'b1; hs.id_rd = 5'd1;
      #0.5;
      chk("waw_free_stall", 32'(hs.stall), 32'd0);
      quiet();
      #0.5;
      src(5'd3, 5'd0, 2'b01);
      #0.5;
      chk("prerst_stall", 32'(hs.stall), 32'd1);
      rst_n = 1'b0;
      #0.5;
      chk("async_pend", 32'(hs.pend_cnt), 32'd0);
      chk("async_full", 32'(hs.sb_full), 32'd0);
      chk("async_stall", 32'(hs.stall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      src(5'd4, 5'd2, 2'b11);
      #1;
      chk("postrst_stall", 32'(hs.stall), 32'd0);
      chk("postrst_pend", 32'(hs.pend_cnt), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
